// File: rtl/fpu_pkg.sv
// Shared FPU controller types and constants: op descriptor, special-value
// encodings and an elaboration-time integer square root for table builds.
package fpu_pkg;

  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam int          FP_TAG_W   = 5;

  typedef struct packed {
    logic                id;
    logic [FP_TAG_W-1:0] tag;
    logic [31:0]         x;
  } fp_op_t;

  function automatic logic [63:0] isqrt64(input logic [63:0] n);
    logic [63:0] rem;
    logic [63:0] res;
    logic [63:0] bit_v;
    rem = n;
    res = '0;
    for (int k = 31; k >= 0; k--) begin
      bit_v = 64'd1 << (2 * k);
      if (rem >= res + bit_v) begin
        rem = rem - (res + bit_v);
        res = (res >> 1) + bit_v;
      end else begin
        res = res >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sqrt.sv
// Combinational single-precision square root for positive normal operands:
// piecewise-linear table over [1,4) with the exponent halved alongside.
module sqrt
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [24:0] ev_tab [17];
  logic [24:0] od_tab [17];

  // Segment start points of sqrt(m) and sqrt(2m), m = 1 + g/16, in Q1.23.
  for (genvar g = 0; g < 17; g++) begin : g_tab
    localparam logic [24:0] EV = 25'(isqrt64(64'(16 + g) << 42));
    localparam logic [24:0] OD = 25'(isqrt64(64'(16 + g) << 43));
    assign ev_tab[g] = EV;
    assign od_tab[g] = OD;
  end

  logic        odd;
  logic [4:0]  idx;
  logic [18:0] frac;
  logic [24:0] base;
  logic [24:0] nxt;
  logic [24:0] slope;
  logic [43:0] prod;
  logic [24:0] sum;
  logic [8:0]  exp_y;
  logic        unused_ok;

  always_comb begin
    odd   = ~x[23];
    idx   = {1'b0, x[22:19]};
    frac  = x[18:0];
    base  = odd ? od_tab[idx] : ev_tab[idx];
    nxt   = odd ? od_tab[idx + 5'd1] : ev_tab[idx + 5'd1];
    slope = nxt - base;
    prod  = 44'(slope) * 44'(frac);
    sum   = base + prod[43:19];
    exp_y = ((9'(x[30:23]) + 9'd1) >> 1) + 9'd63;
    y     = {1'b0, exp_y[7:0], sum[22:0]};
  end

  assign unused_ok = ^{clk, rstn, x[31], prod[18:0], sum[24:23], exp_y[8]};

endmodule

// File: rtl/fsqrt_arbiter.sv
// Two-requester round-robin front end for a shared combinational sqrt,
// with an operand stage, special-operand handling and a stallable result stage.
module fsqrt_arbiter
  import fpu_pkg::*;
#(
  parameter int TAG_W = FP_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       req_valid,
  input  logic [31:0]      req_x0,
  input  logic [31:0]      req_x1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic [1:0]       req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_y,
  output logic             busy
);

  function automatic logic [31:0] select_result(input logic [31:0] x,
                                                input logic [31:0] root);
    if (x[30:23] == 8'd0)            return 32'h0000_0000;
    else if (x[30:23] == FP_EXP_MAX) return x;
    else if (x[31])                  return FP_QNAN;
    else                             return root;
  endfunction

  logic             s1_vld_q, s1_vld_d;
  fp_op_t           s1_q, s1_d;
  logic             last_q, last_d;
  logic             rsp_vld_q, rsp_vld_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [31:0]      rsp_y_q, rsp_y_d;
  logic [31:0]      sqrt_y;
  logic [1:0]       grant;
  logic             s2_hold, s1_adv, can_accept, accept;

  sqrt u_sqrt (
    .clk  (clk),
    .rstn (rstn),
    .x    (s1_q.x),
    .y    (sqrt_y)
  );

  always_comb begin
    s2_hold    = rsp_vld_q && !rsp_ready;
    s1_adv     = s1_vld_q && !s2_hold;
    can_accept = !s1_vld_q || s1_adv;

    // last_q names the requester granted most recently; the other wins a tie.
    grant = req_valid;
    if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    req_ready = grant & {2{can_accept}};
    accept    = |req_ready;
    last_d    = accept ? req_ready[1] : last_q;

    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_d.id  = req_ready[1];
      s1_d.tag = req_ready[1] ? FP_TAG_W'(req_tag1) : FP_TAG_W'(req_tag0);
      s1_d.x   = req_ready[1] ? req_x1 : req_x0;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    rsp_tag_d = rsp_tag_q;
    rsp_y_d   = rsp_y_q;
    if (!s2_hold) begin
      rsp_vld_d = s1_vld_q;
      rsp_id_d  = s1_q.id;
      rsp_tag_d = TAG_W'(s1_q.tag);
      rsp_y_d   = select_result(s1_q.x, sqrt_y);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      last_q    <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= 1'b0;
      rsp_tag_q <= '0;
      rsp_y_q   <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      last_q    <= last_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_y_q   <= rsp_y_d;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = s1_vld_q || rsp_vld_q;

endmodule
